// File: rtl/sha_pkg.sv
// Shared SHA-256/224 constants and the message sequencer state encoding.
package sha_pkg;

    localparam int WORD_W        = 32;
    localparam int BLOCK_W       = 512;
    localparam int WORDS_PER_BLK = 16;
    localparam int DIGEST_W      = 256;
    localparam int ROUNDS        = 64;

    localparam logic [255:0] IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    // Padding word that carries the 0x80 marker in its first byte.
    localparam logic [31:0] PAD_WORD0 = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PAD   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_EXTRA = 3'd5
    } seq_state_t;

    // LSB position of block word w; word 0 sits in the top 32 bits.
    function automatic logic [8:0] word_lsb(input logic [3:0] w);
        return {~w, 5'b00000};
    endfunction

endpackage

// File: rtl/sha_pad_insert.sv
// Keeps the leading i_nbytes bytes of a big-endian word and, for a partial
// word, places the 0x80 padding marker right after the last data byte.
module sha_pad_insert (
    input  logic [31:0] i_word,
    input  logic [2:0]  i_nbytes,
    output logic [31:0] o_masked,
    output logic [31:0] o_padded
);

    logic [31:0] w_mask;
    logic [31:0] w_marker;

    // Byte mask and marker position from the valid-byte count (>=4 = full word).
    always_comb begin
        w_mask   = 32'hFFFF_FFFF;
        w_marker = 32'h0000_0000;
        case (i_nbytes)
            3'd0: begin w_mask = 32'h0000_0000; w_marker = 32'h8000_0000; end
            3'd1: begin w_mask = 32'hFF00_0000; w_marker = 32'h0080_0000; end
            3'd2: begin w_mask = 32'hFFFF_0000; w_marker = 32'h0000_8000; end
            3'd3: begin w_mask = 32'hFFFF_FF00; w_marker = 32'h0000_0080; end
            default: begin w_mask = 32'hFFFF_FFFF; w_marker = 32'h0000_0000; end
        endcase
    end

    assign o_masked = i_word & w_mask;
    assign o_padded = o_masked | w_marker;

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Streams a byte message as 32-bit words, applies SHA-2 padding plus the
// 64-bit bit length, and feeds the hash core one 512-bit block at a time.
module sha256_msg_sequencer #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         mode_in,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output logic         s_ready,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic         core_valid_digest,
    input  logic [255:0] core_digest,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    import sha_pkg::*;

    seq_state_t         r_state;
    logic [511:0]       r_buf;
    logic [3:0]         r_ptr;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [2:0]         r_last_bytes;
    logic               r_first_blk;
    logic               r_extra_pend;
    logic               r_pad_w0;
    logic               r_final;
    logic               r_mode;
    logic               r_core_init;
    logic               r_core_next;
    logic [255:0]       r_digest;
    logic               r_digest_valid;

    logic [31:0]        w_cur_word;
    logic [31:0]        w_pi_word;
    logic [2:0]         w_pi_nbytes;
    logic [31:0]        w_masked;
    logic [31:0]        w_padded;
    logic               w_full_last;
    logic [4:0]         w_q;
    logic [63:0]        w_bitlen;
    logic               w_digest_seen;

    assign w_cur_word  = r_buf[word_lsb(r_ptr) +: 32];
    assign w_full_last = (r_last_bytes >= 3'd4);
    // Word index that receives the 0x80 marker (16 = spills past the block).
    assign w_q         = w_full_last ? ({1'b0, r_ptr} + 5'd1) : {1'b0, r_ptr};
    assign w_bitlen    = 64'({r_byte_cnt, 3'b000});

    // One masking unit: incoming last word while filling, stored word during PAD.
    assign w_pi_word   = (r_state == ST_FILL) ? s_data  : w_cur_word;
    assign w_pi_nbytes = (r_state == ST_FILL) ? s_bytes : r_last_bytes;

    sha_pad_insert u_pad (
        .i_word   (w_pi_word),
        .i_nbytes (w_pi_nbytes),
        .o_masked (w_masked),
        .o_padded (w_padded)
    );

    // The core still shows the previous digest while our issue pulse is out;
    // it only clears valid on the edge that samples the pulse.
    assign w_digest_seen = core_valid_digest & ~r_core_init & ~r_core_next;

    // Sequencer FSM: fill, pad, issue each block and collect the digest.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= ST_IDLE;
            r_buf          <= '0;
            r_ptr          <= '0;
            r_byte_cnt     <= '0;
            r_last_bytes   <= '0;
            r_first_blk    <= 1'b1;
            r_extra_pend   <= 1'b0;
            r_pad_w0       <= 1'b0;
            r_final        <= 1'b0;
            r_mode         <= 1'b0;
            r_core_init    <= 1'b0;
            r_core_next    <= 1'b0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode         <= mode_in;
                        r_byte_cnt     <= '0;
                        r_buf          <= '0;
                        r_ptr          <= '0;
                        r_first_blk    <= 1'b1;
                        r_extra_pend   <= 1'b0;
                        r_pad_w0       <= 1'b0;
                        r_final        <= 1'b0;
                        r_digest_valid <= 1'b0;
                        r_state        <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (s_valid) begin
                        if (s_last) begin
                            r_buf[word_lsb(r_ptr) +: 32] <= w_masked;
                            r_byte_cnt   <= r_byte_cnt + CNT_W'(s_bytes);
                            r_last_bytes <= s_bytes;
                            r_state      <= ST_PAD;
                        end else begin
                            r_buf[word_lsb(r_ptr) +: 32] <= s_data;
                            r_byte_cnt <= r_byte_cnt + CNT_W'(4);
                            r_ptr      <= r_ptr + 4'd1;
                            if (r_ptr == 4'd15) r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_PAD: begin
                    if (!w_full_last)
                        r_buf[word_lsb(r_ptr) +: 32] <= w_padded;
                    else if (r_ptr != 4'd15)
                        r_buf[word_lsb(r_ptr + 4'd1) +: 32] <= PAD_WORD0;
                    if (w_q <= 5'd13) begin
                        r_buf[63:0] <= w_bitlen;
                        r_final     <= 1'b1;
                    end else begin
                        r_extra_pend <= 1'b1;
                        r_pad_w0     <= (w_q == 5'd16);
                    end
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (core_ready) begin
                        if (r_first_blk) r_core_init <= 1'b1;
                        else             r_core_next <= 1'b1;
                        r_first_blk <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_digest_seen) begin
                        if (r_extra_pend) begin
                            r_buf   <= '0;
                            r_state <= ST_EXTRA;
                        end else if (r_final) begin
                            r_digest       <= core_digest;
                            r_digest_valid <= 1'b1;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_buf   <= '0;
                            r_ptr   <= '0;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_EXTRA: begin
                    r_buf[511:480] <= r_pad_w0 ? PAD_WORD0 : 32'h0;
                    r_buf[63:0]    <= w_bitlen;
                    r_extra_pend   <= 1'b0;
                    r_final        <= 1'b1;
                    r_state        <= ST_ISSUE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready      = (r_state == ST_FILL);
    assign busy         = (r_state != ST_IDLE);
    assign core_init    = r_core_init;
    assign core_next    = r_core_next;
    assign core_mode    = r_mode;
    assign core_block   = r_buf;
    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer: a behavioural SHA-256/224 core, a byte-level
// padding model feeding an expected-block queue, and known-answer digests.
module tb_sha256_msg_sequencer;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         mode_in = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic [2:0]   s_bytes = '0;
    logic         s_ready;
    logic         core_init, core_next, core_mode;
    logic [511:0] core_block;
    logic         core_ready;
    logic         core_valid_digest;
    logic [255:0] core_digest;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sha256_msg_sequencer #(.CNT_W(61)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .mode_in(mode_in),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_bytes(s_bytes),
        .s_ready(s_ready), .core_init(core_init), .core_next(core_next),
        .core_mode(core_mode), .core_block(core_block), .core_ready(core_ready),
        .core_valid_digest(core_valid_digest), .core_digest(core_digest),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- behavioural hash core ----------------
    logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [255:0] iv_of(input logic m);
        return m ? {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19}
                 : {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    endfunction

    logic         c_busy, c_vld, c_mode;
    logic [255:0] c_H, c_pend;
    int           c_cnt;
    int           lat = 4;
    bit           stall = 1'b0;

    assign core_ready        = !c_busy && !stall;
    assign core_valid_digest = c_vld;
    assign core_digest       = c_mode ? c_H : {c_H[255:32], 32'h0};

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            c_busy <= 1'b0; c_vld <= 1'b0; c_mode <= 1'b0;
            c_H <= '0; c_pend <= '0; c_cnt <= 0;
        end else if (core_init || core_next) begin
            c_pend <= sha_comp(core_init ? iv_of(core_mode) : c_H, core_block);
            c_mode <= core_init ? core_mode : c_mode;
            c_busy <= 1'b1;
            c_vld  <= 1'b0;
            c_cnt  <= lat;
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                c_busy <= 1'b0; c_vld <= 1'b1; c_H <= c_pend;
            end else c_cnt <= c_cnt - 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0]   m [$];
    logic [511:0] exp_blk [$];
    bit           exp_kind [$];

    always @(negedge clk) begin
        if (n_rst && (core_init || core_next)) begin
            chk("pulse_excl", {511'b0, core_init & core_next}, 512'b0);
            if (exp_blk.size() == 0) chk("unexp_issue", 512'd1, 512'd0);
            else begin
                chk("issue_kind", {511'b0, core_init}, {511'b0, exp_kind.pop_front()});
                chk("issue_block", core_block, exp_blk.pop_front());
            end
        end
    end

    task automatic set_str(input string s);
        m.delete();
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    endtask

    task automatic set_seq(input int n);
        m.delete();
        for (int i = 0; i < n; i++) m.push_back(8'(i * 7 + 3));
    endtask

    // Reference padding done on a byte array: 0x80, zeros to 56 mod 64, 64-bit length.
    task automatic push_expected();
        logic [7:0]   p [$];
        logic [63:0]  bl;
        logic [511:0] blk;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int j = 0; j < 8; j++) p.push_back(bl[63 - 8*j -: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
            exp_blk.push_back(blk);
            exp_kind.push_back(b == 0);
        end
    endtask

    task automatic send_msg(input logic mode);
        int nw, cyc;
        logic [31:0] w;
        cyc = 0;
        while (busy && cyc < 2000) begin @(negedge clk); cyc++; end
        if (busy) chk("tmo_idle", 512'd0, 512'd1);
        start = 1'b1; mode_in = mode;
        @(negedge clk);
        start = 1'b0; mode_in = 1'b0;
        nw = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 4; j++)
                w[31 - 8*j -: 8] = (4*i + j < m.size()) ? m[4*i + j] : 8'hA5;
            s_data  = w;
            s_valid = 1'b1;
            s_last  = (i == nw - 1);
            s_bytes = (i == nw - 1) ? 3'(m.size() - 4*i) : 3'd4;
            cyc = 0;
            while (!s_ready && cyc < 200) begin @(negedge clk); cyc++; end
            if (!s_ready) chk("tmo_sready", 512'd0, 512'd1);
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string tag, input bit dchk, input logic [255:0] dexp,
                             input logic [255:0] dmask);
        int cyc;
        cyc = 0;
        while (!digest_valid && cyc < 3000) begin @(negedge clk); cyc++; end
        if (!digest_valid) chk({tag, "_tmo"}, 512'd0, 512'd1);
        if (dchk) chk({tag, "_digest"}, {256'b0, digest & dmask}, {256'b0, dexp & dmask});
        chk({tag, "_blocks_left"}, 512'(exp_blk.size()), 512'd0);
        chk({tag, "_idle"}, {511'b0, busy}, 512'd0);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},   {511'b0, busy},         512'd0);
        chk({pfx, "_sready"}, {511'b0, s_ready},      512'd0);
        chk({pfx, "_init"},   {511'b0, core_init},    512'd0);
        chk({pfx, "_next"},   {511'b0, core_next},    512'd0);
        chk({pfx, "_mode"},   {511'b0, core_mode},    512'd0);
        chk({pfx, "_block"},  core_block,             512'd0);
        chk({pfx, "_digest"}, {256'b0, digest},       512'd0);
        chk({pfx, "_dvalid"}, {511'b0, digest_valid}, 512'd0);
    endtask

    localparam logic [255:0] FULL = {256{1'b1}};
    localparam logic [255:0] TOP7 = {{224{1'b1}}, 32'h0};
    localparam logic [255:0] D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
    localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_56     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    initial begin
        int lens [6];
        int cyc;
        lens = '{52, 55, 59, 62, 64, 130};

        repeat (3) @(negedge clk);
        chk_zero("rst");
        n_rst = 1'b1;
        @(negedge clk);

        set_str("abc"); push_expected(); send_msg(1'b1);
        wait_done("abc256", 1'b1, D_ABC256, FULL);

        set_str("abc"); push_expected(); send_msg(1'b0);
        wait_done("abc224", 1'b1, D_ABC224, TOP7);

        m.delete(); push_expected(); send_msg(1'b1);
        wait_done("empty", 1'b1, D_EMPTY, FULL);

        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        push_expected(); send_msg(1'b1);
        wait_done("msg56", 1'b1, D_56, FULL);

        // Padding boundaries: q=13, q=13, q=14, q=15, q=16 (extra block), multi-block.
        foreach (lens[i]) begin
            set_seq(lens[i]); push_expected(); send_msg(1'b1);
            wait_done($sformatf("len%0d", lens[i]), 1'b0, '0, FULL);
        end

        // Core held not-ready in ISSUE; a start pulse while busy must be ignored.
        stall = 1'b1;
        set_str("abc"); push_expected(); send_msg(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("stall_nopulse", {511'b0, core_init | core_next}, 512'd0);
            chk("stall_busy", {511'b0, busy}, 512'd1);
        end
        chk("stall_mode_kept", {511'b0, core_mode}, 512'd1);
        stall = 1'b0;
        wait_done("stall", 1'b1, D_ABC256, FULL);

        // Reset while waiting on the core.
        lat = 30;
        set_str("abc"); push_expected(); send_msg(1'b1);
        cyc = 0;
        while (!core_init && cyc < 200) begin @(negedge clk); cyc++; end
        if (!core_init) chk("tmo_rst_init", 512'd0, 512'd1);
        repeat (3) @(negedge clk);
        chk("midrst_busy", {511'b0, busy}, 512'd1);
        n_rst = 1'b0;
        #1;
        chk_zero("midrst");
        exp_blk.delete(); exp_kind.delete();
        @(negedge clk);
        n_rst = 1'b1;
        lat = 4;
        @(negedge clk);

        m.delete(); push_expected(); send_msg(1'b1);
        wait_done("post_rst", 1'b1, D_EMPTY, FULL);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
